// File: rtl/eth_tx_drv.sv
`timescale 1ns/1ps
// eth_tx_drv
// Ethernet transmit driver. Accepts one complete fixed-size frame per
// valid/ready handshake and serialises it onto a byte-wide GMII-style PHY
// transmit interface as preamble, SFD, frame data, CRC-32 FCS, then a forced
// inter-frame gap.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-low reset
//   tx_drv_wr_data  frame to send; byte 0 is the most significant byte
//   tx_drv_wr_valid writer offers a frame
//   tx_drv_wr_ready registered; driver is idle and can take a frame
//   phy_txd         transmit byte
//   phy_tx_en       phy_txd carries a valid byte
//   tx_fsm_state    current FSM state encoding (debug/status)
//   tx_frame_count  frames fully transmitted, wraps at 16 bits
module eth_tx_drv #(
  parameter int ETH_MAX_FRAME_SIZE = 256,
  parameter int PREAMBLE_BYTES     = 7,
  parameter int IFG_BYTES          = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ETH_MAX_FRAME_SIZE-1:0] tx_drv_wr_data,
  input  logic                          tx_drv_wr_valid,
  output logic                          tx_drv_wr_ready,
  output logic [7:0]                    phy_txd,
  output logic                          phy_tx_en,
  output logic [2:0]                    tx_fsm_state,
  output logic [15:0]                   tx_frame_count
);

  localparam int NB        = ETH_MAX_FRAME_SIZE / 8;
  localparam int FCS_BYTES = 4;
  localparam int MSB       = ETH_MAX_FRAME_SIZE - 1;

  // The shared byte counter must reach the longest state length minus one.
  localparam int MAX_LEN_A = (NB > PREAMBLE_BYTES) ? NB : PREAMBLE_BYTES;
  localparam int MAX_LEN_B = (MAX_LEN_A > IFG_BYTES) ? MAX_LEN_A : IFG_BYTES;
  localparam int MAX_LEN   = (MAX_LEN_B > FCS_BYTES) ? MAX_LEN_B : FCS_BYTES;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(FCS_BYTES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST  = CNT_W'(IFG_BYTES - 1);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
    FCS      = 3'd4,
    IFG      = 3'd5
  } tx_state_t;

  tx_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MSB:0]            shift_q;
  logic [31:0]             crc_q;
  logic [31:0]             fcs;
  logic [7:0]              fcs_byte;
  logic                    accept;

  // Reflected CRC-32 update for one byte, bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign accept       = (state_q == IDLE) && tx_drv_wr_valid && tx_drv_wr_ready;
  assign fcs          = ~crc_q;
  assign tx_fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts on every state change and holds at zero in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept)               state_d = PREAMBLE;
      PREAMBLE: if (cnt_q == PRE_LAST)    state_d = SFD;
      SFD:                                state_d = DATA;
      DATA:     if (cnt_q == DATA_LAST)   state_d = FCS;
      FCS:      if (cnt_q == FCS_LAST)    state_d = IFG;
      IFG:      if (cnt_q == IFG_LAST)    state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + 1'b1;
  end

  // FCS goes out least-significant byte first, indexed by the next count.
  always_comb begin
    fcs_byte = fcs[7:0];
    case (cnt_d[1:0])
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      2'd3:    fcs_byte = fcs[31:24];
      default: fcs_byte = fcs[7:0];
    endcase
  end

  // Outputs are registered from the next state, so each output byte lines up
  // with the cycle in which tx_fsm_state shows the state that produced it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_drv_wr_ready <= 1'b0;
      phy_tx_en       <= 1'b0;
      phy_txd         <= 8'h00;
      tx_frame_count  <= 16'h0000;
      shift_q         <= '0;
      crc_q           <= '0;
    end else begin
      tx_drv_wr_ready <= (state_d == IDLE);
      phy_tx_en       <= (state_d == PREAMBLE) || (state_d == SFD) ||
                         (state_d == DATA) || (state_d == FCS);
      phy_txd         <= 8'h00;
      if (accept) begin
        shift_q <= tx_drv_wr_data;
        crc_q   <= 32'hFFFFFFFF;
      end
      case (state_d)
        PREAMBLE: phy_txd <= 8'h55;
        SFD:      phy_txd <= 8'hD5;
        DATA: begin
          phy_txd <= shift_q[MSB -: 8];
          shift_q <= shift_q << 8;
          crc_q   <= crc32_byte(crc_q, shift_q[MSB -: 8]);
        end
        FCS:      phy_txd <= fcs_byte;
        default:  phy_txd <= 8'h00;
      endcase
      if ((state_d == FCS) && (cnt_d == FCS_LAST)) begin
        tx_frame_count <= tx_frame_count + 16'd1;
      end
    end
  end

endmodule
